// File: rtl/call_ret_if.sv
// Decode/stack/fetch-side bundle for call_ret_ctrl.
// slave is the sequencer's view; master is the decode, stack and fetch side.
interface call_ret_if #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 32768
);
    localparam int DW = $clog2(DEPTH) + 1;

    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [WIDTH-1:0] req_pc;
    logic [WIDTH-1:0] req_target;
    logic             stk_push;
    logic             stk_pop;
    logic [WIDTH-1:0] stk_wdata;
    logic [WIDTH-1:0] stk_top;
    logic             pc_valid;
    logic [WIDTH-1:0] pc_next;
    logic [DW-1:0]    depth;
    logic             err_overflow;
    logic             err_underflow;

    modport slave (
        input  req_valid, req_op, req_pc, req_target, stk_top,
        output req_ready, stk_push, stk_pop, stk_wdata, pc_valid, pc_next,
               depth, err_overflow, err_underflow
    );

    modport master (
        output req_valid, req_op, req_pc, req_target, stk_top,
        input  req_ready, stk_push, stk_pop, stk_wdata, pc_valid, pc_next,
               depth, err_overflow, err_underflow
    );
endinterface

// File: rtl/call_ret_ctrl.sv
// Call/return sequencer driving the return-address stack and redirecting fetch.
// Define STACK_GUARD_EN to enable the depth counter and overflow/underflow guard.
module call_ret_ctrl #(
    parameter int WIDTH       = 18,
    parameter int DEPTH       = 32768,
    parameter int POP_LATENCY = 1
) (
    input logic      clk,
    input logic      rst,
    call_ret_if.slave bus
);
    localparam int DW = $clog2(DEPTH) + 1;

    localparam logic [1:0] OP_SEQ  = 2'b00;
    localparam logic [1:0] OP_CALL = 2'b01;
    localparam logic [1:0] OP_RET  = 2'b10;
    localparam logic [1:0] OP_JUMP = 2'b11;

    typedef enum logic [1:0] {IDLE, PUSH, POPW} state_t;

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             push_q, push_d;
    logic             pop_q, pop_d;
    logic             pcv_q, pcv_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] pcn_q, pcn_d;
    logic [WIDTH-1:0] pc_inc;
    logic             accept;
    logic             full;
    logic             empty;

`ifdef STACK_GUARD_EN
    logic [DW-1:0] depth_q, depth_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;

    assign full  = (depth_q == DW'(DEPTH));
    assign empty = (depth_q == '0);
`else
    assign full  = 1'b0;
    assign empty = 1'b0;
`endif

    // Wraps modulo 2^WIDTH; the carry is intentionally dropped.
    assign pc_inc = bus.req_pc + WIDTH'(1);
    assign accept = bus.req_valid && (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        push_d  = 1'b0;
        pop_d   = 1'b0;
        pcv_d   = 1'b0;
        wdata_d = wdata_q;
        pcn_d   = pcn_q;
`ifdef STACK_GUARD_EN
        depth_d = depth_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
`endif
        case (state_q)
            IDLE: if (accept) begin
                case (bus.req_op)
                    OP_SEQ: begin
                        pcn_d = pc_inc;
                        pcv_d = 1'b1;
                    end
                    OP_JUMP: begin
                        pcn_d = bus.req_target;
                        pcv_d = 1'b1;
                    end
                    OP_CALL: begin
                        pcv_d = 1'b1;
                        if (full) begin
                            // Refused call falls through to the next instruction.
                            pcn_d = pc_inc;
`ifdef STACK_GUARD_EN
                            ovf_d = 1'b1;
`endif
                        end else begin
                            push_d  = 1'b1;
                            wdata_d = pc_inc;
                            pcn_d   = bus.req_target;
                            state_d = PUSH;
`ifdef STACK_GUARD_EN
                            depth_d = depth_q + DW'(1);
`endif
                        end
                    end
                    OP_RET: begin
                        if (empty) begin
                            pcn_d = pc_inc;
                            pcv_d = 1'b1;
`ifdef STACK_GUARD_EN
                            udf_d = 1'b1;
`endif
                        end else begin
                            pop_d   = 1'b1;
                            cnt_d   = 3'(POP_LATENCY);
                            state_d = POPW;
`ifdef STACK_GUARD_EN
                            depth_d = depth_q - DW'(1);
`endif
                        end
                    end
                    default: ;
                endcase
            end
            PUSH: state_d = IDLE;
            POPW: begin
                // Counter hits 0 at edge N+POP_LATENCY; stk_top is taken one edge later.
                if (cnt_q == 3'd0) begin
                    pcn_d   = bus.stk_top;
                    pcv_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            push_q  <= 1'b0;
            pop_q   <= 1'b0;
            pcv_q   <= 1'b0;
            wdata_q <= '0;
            pcn_q   <= '0;
`ifdef STACK_GUARD_EN
            depth_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            push_q  <= push_d;
            pop_q   <= pop_d;
            pcv_q   <= pcv_d;
            wdata_q <= wdata_d;
            pcn_q   <= pcn_d;
`ifdef STACK_GUARD_EN
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
`endif
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.stk_push  = push_q;
    assign bus.stk_pop   = pop_q;
    assign bus.stk_wdata = wdata_q;
    assign bus.pc_valid  = pcv_q;
    assign bus.pc_next   = pcn_q;
`ifdef STACK_GUARD_EN
    assign bus.depth         = depth_q;
    assign bus.err_overflow  = ovf_q;
    assign bus.err_underflow = udf_q;
`else
    assign bus.depth         = '0;
    assign bus.err_overflow  = 1'b0;
    assign bus.err_underflow = 1'b0;
`endif
endmodule

// File: tb/tb_call_ret_ctrl.sv
// Directed bench for call_ret_ctrl: one instance at POP_LATENCY=1, one at 3, both DEPTH=4.
module tb_call_ret_ctrl;
    localparam int W = 18;
`ifdef STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nerr = 0;
    int   cnt_v;
    int   cnt_nr;

    always #5 clk = ~clk;

    call_ret_if #(.WIDTH(W), .DEPTH(4)) ifa ();
    call_ret_if #(.WIDTH(W), .DEPTH(4)) ifb ();

    call_ret_ctrl #(.WIDTH(W), .DEPTH(4), .POP_LATENCY(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    call_ret_ctrl #(.WIDTH(W), .DEPTH(4), .POP_LATENCY(3)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic req_a(input logic [1:0] op, input logic [W-1:0] pc, input logic [W-1:0] tgt);
        ifa.req_valid  = 1'b1;
        ifa.req_op     = op;
        ifa.req_pc     = pc;
        ifa.req_target = tgt;
    endtask

    task automatic req_b(input logic [1:0] op, input logic [W-1:0] pc, input logic [W-1:0] tgt);
        ifb.req_valid  = 1'b1;
        ifb.req_op     = op;
        ifb.req_pc     = pc;
        ifb.req_target = tgt;
    endtask

    initial begin
        ifa.req_valid = 1'b0; ifa.req_op = 2'b00; ifa.req_pc = '0; ifa.req_target = '0; ifa.stk_top = '0;
        ifb.req_valid = 1'b0; ifb.req_op = 2'b00; ifb.req_pc = '0; ifb.req_target = '0; ifb.stk_top = '0;
        step(); step();
        rst = 1'b0;
        step();

        // Reset state
        chk("rst_ready", ifa.req_ready, 1);
        chk("rst_pcv", ifa.pc_valid, 0);
        chk("rst_pcnext", ifa.pc_next, 0);
        chk("rst_wdata", ifa.stk_wdata, 0);
        chk("rst_push_pop", {ifa.stk_push, ifa.stk_pop}, 0);
        chk("rst_depth", ifa.depth, 0);
        chk("rst_errs", {ifa.err_overflow, ifa.err_underflow}, 0);

        // SEQ
        req_a(2'b00, 18'h00010, 18'h0);
        step();
        ifa.req_valid = 1'b0;
        chk("seq_pcv", ifa.pc_valid, 1);
        chk("seq_pcnext", ifa.pc_next, 18'h00011);
        step();
        chk("seq_pcv_drop", ifa.pc_valid, 0);

        // CALL
        req_a(2'b01, 18'h00100, 18'h02000);
        step();
        ifa.req_valid = 1'b0;
        chk("call_push", ifa.stk_push, 1);
        chk("call_wdata", ifa.stk_wdata, 18'h00101);
        chk("call_pcv", ifa.pc_valid, 1);
        chk("call_pcnext", ifa.pc_next, 18'h02000);
        chk("call_ready", ifa.req_ready, 0);
        chk("call_depth", ifa.depth, GUARD ? 1 : 0);
        step();
        chk("push_done", {ifa.stk_push, ifa.pc_valid, ifa.req_ready}, 3'b001);

        // RET, latency 1
        ifa.stk_top = 18'h00101;
        req_a(2'b10, 18'h02005, 18'h0);
        step();
        ifa.req_valid = 1'b0;
        chk("ret_pop", {ifa.stk_pop, ifa.stk_push, ifa.pc_valid, ifa.req_ready}, 4'b1000);
        chk("ret_depth", ifa.depth, 0);
        step();
        chk("ret_wait", {ifa.stk_pop, ifa.pc_valid, ifa.req_ready}, 3'b000);
        step();
        chk("ret_pcv", {ifa.pc_valid, ifa.req_ready}, 2'b11);
        chk("ret_pcnext", ifa.pc_next, 18'h00101);
        chk("ret_wdata_hold", ifa.stk_wdata, 18'h00101);

        // Wrap
        req_a(2'b00, 18'h3FFFF, 18'h0);
        step();
        chk("wrap_seq", ifa.pc_next, 18'h00000);
        req_a(2'b01, 18'h3FFFF, 18'h00005);
        step();
        ifa.req_valid = 1'b0;
        chk("wrap_call_wdata", ifa.stk_wdata, 18'h00000);
        chk("wrap_call_pcnext", ifa.pc_next, 18'h00005);
        step();
        ifa.stk_top = 18'h00000;
        req_a(2'b10, 18'h00009, 18'h0);
        step();
        ifa.req_valid = 1'b0;
        step(); step();
        chk("wrap_ret", {ifa.pc_valid, 14'h0, ifa.pc_next}, {1'b1, 14'h0, 18'h00000});

`ifdef STACK_GUARD_EN
        // Overflow: four pushes then a refused fifth call
        for (int i = 0; i < 5; i++) begin
            req_a(2'b01, 18'h00200 + 18'(i), 18'h00300);
            step();
            ifa.req_valid = 1'b0;
            if (i < 4) begin
                chk("ovf_push", {ifa.stk_push, ifa.err_overflow}, 2'b10);
                chk("ovf_depth", ifa.depth, i + 1);
                step();
            end else begin
                chk("ovf_nopush", {ifa.stk_push, ifa.err_overflow, ifa.pc_valid, ifa.req_ready}, 4'b0111);
                chk("ovf_pcnext", ifa.pc_next, 18'h00205);
                chk("ovf_depth_full", ifa.depth, 4);
            end
        end
        // Underflow: four pops then a refused fifth return
        for (int i = 0; i < 5; i++) begin
            ifa.stk_top = 18'h00400 + 18'(i);
            req_a(2'b10, 18'h00500 + 18'(i), 18'h0);
            step();
            ifa.req_valid = 1'b0;
            if (i < 4) begin
                chk("udf_pop", {ifa.stk_pop, ifa.err_underflow}, 2'b10);
                chk("udf_depth", ifa.depth, 3 - i);
                step(); step();
                chk("udf_ret_pc", ifa.pc_next, 18'h00400 + 18'(i));
            end else begin
                chk("udf_nopop", {ifa.stk_pop, ifa.err_underflow, ifa.pc_valid, ifa.req_ready}, 4'b0111);
                chk("udf_pcnext", ifa.pc_next, 18'h00505);
                chk("udf_ovf_sticky", ifa.err_overflow, 1);
            end
        end
`endif

        // Back-to-back: JUMP, JUMP, CALL, SEQ offered continuously over 5 edges
        cnt_v  = 0;
        cnt_nr = 0;
        req_a(2'b11, 18'h0, 18'h00040);
        step();
        chk("b2b_j1", ifa.pc_next, 18'h00040);
        cnt_v  += int'(ifa.pc_valid);
        cnt_nr += int'(!ifa.req_ready);
        req_a(2'b11, 18'h0, 18'h00050);
        step();
        chk("b2b_j2", ifa.pc_next, 18'h00050);
        cnt_v  += int'(ifa.pc_valid);
        cnt_nr += int'(!ifa.req_ready);
        req_a(2'b01, 18'h00060, 18'h00070);
        step();
        chk("b2b_call", {ifa.stk_push, ifa.req_ready, 14'h0, ifa.pc_next}, {2'b10, 14'h0, 18'h00070});
        cnt_v  += int'(ifa.pc_valid);
        cnt_nr += int'(!ifa.req_ready);
        req_a(2'b00, 18'h00080, 18'h0);
        step();
        chk("b2b_push_cycle", {ifa.pc_valid, ifa.req_ready}, 2'b01);
        cnt_v  += int'(ifa.pc_valid);
        cnt_nr += int'(!ifa.req_ready);
        step();
        ifa.req_valid = 1'b0;
        chk("b2b_seq", ifa.pc_next, 18'h00081);
        cnt_v  += int'(ifa.pc_valid);
        cnt_nr += int'(!ifa.req_ready);
        chk("b2b_pcv_count", cnt_v, 4);
        chk("b2b_notready_count", cnt_nr, 1);

        // Reset mid-POPW on the latency-3 instance
        req_b(2'b01, 18'h00010, 18'h00020);
        step();
        ifb.req_valid = 1'b0;
        step();
        ifb.stk_top = 18'h00999;
        req_b(2'b10, 18'h00020, 18'h0);
        step();
        ifb.req_valid = 1'b0;
        chk("b_pop", ifb.stk_pop, 1);
        step();
        rst = 1'b1;
        step();
        chk("b_rst_state", {ifb.pc_valid, ifb.stk_pop, ifb.stk_push, ifb.req_ready}, 4'b0001);
        chk("b_rst_depth", ifb.depth, 0);
        chk("b_rst_regs", {ifb.pc_next, ifb.stk_wdata}, 0);
        rst = 1'b0;
        req_b(2'b11, 18'h0, 18'h00040);
        step();
        ifb.req_valid = 1'b0;
        chk("b_jump_pcv", ifb.pc_valid, 1);
        chk("b_jump_pcnext", ifb.pc_next, 18'h00040);
        cnt_v = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            cnt_v += int'(ifb.pc_valid);
        end
        chk("b_no_stale_pcv", cnt_v, 0);
        chk("b_pcnext_hold", ifb.pc_next, 18'h00040);
        chk("a_rst_errs", {ifa.err_overflow, ifa.err_underflow, ifa.depth}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
